// File: rtl/cmp_slice_seq_if.sv
// Operand/result handshake bundle between the ALU control FSM and the slice compare sequencer.
interface cmp_slice_seq_if #(
   parameter int unsigned WIDTH = 6
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             res_valid;
   logic             res_ready;
   logic             gt;
   logic             eq;
   logic             ge;

   modport master (
      output start_valid, a, b, res_ready,
      input  start_ready, res_valid, gt, eq, ge
   );

   modport slave (
      input  start_valid, a, b, res_ready,
      output start_ready, res_valid, gt, eq, ge
   );
endinterface

// File: rtl/cmp_slice_seq.sv
// Multi-cycle unsigned magnitude comparator: walks operands MSB-first in 2-bit slices,
// stopping at the first unequal slice, and returns gt/eq/ge over a valid/ready handshake.
module cmp_slice_seq #(
   parameter int unsigned WIDTH = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   cmp_slice_seq_if.slave     bus
);
   localparam int unsigned SLICES = WIDTH / 2;
   localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_gt;
   logic             r_eq;

   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [1:0]       w_sa;
   logic [1:0]       w_sb;

   // Current slice sits at bit 2*idx; shift it down to the bottom two bits.
   assign w_a_sh = r_a >> {r_idx, 1'b0};
   assign w_b_sh = r_b >> {r_idx, 1'b0};
   assign w_sa   = w_a_sh[1:0];
   assign w_sb   = w_b_sh[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
      end else if (clr) begin
         r_state <= IDLE;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_idx   <= IDX_W'(SLICES - 1);
                  r_gt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_sa > w_sb) begin
                  r_gt    <= 1'b1;
                  r_eq    <= 1'b0;
                  r_state <= DONE;
               end else if (w_sa < w_sb) begin
                  r_gt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_state <= DONE;
               end else if (r_idx == '0) begin
                  r_gt    <= 1'b0;
                  r_eq    <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx - IDX_W'(1);
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Handshake flags decode from state only; result bits come straight from registers.
   assign bus.start_ready = (r_state == IDLE);
   assign bus.res_valid   = (r_state == DONE);
   assign bus.gt          = r_gt;
   assign bus.eq          = r_eq;
   assign bus.ge          = r_gt | r_eq;
endmodule

// File: tb/tb_cmp_slice_seq.sv
// Directed self-checking bench for cmp_slice_seq at WIDTH=6.
module tb_cmp_slice_seq;
   localparam int unsigned WIDTH = 6;

   logic clk;
   logic rst_n;
   logic clr;
   int   n_assert;
   int   n_fail;

   cmp_slice_seq_if #(.WIDTH(WIDTH)) bus ();

   cmp_slice_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges from acceptance until res_valid, bounded.
   task automatic wait_result(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!bus.res_valid && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
   endtask

   task automatic accept(input logic [5:0] av, input logic [5:0] bv);
      check("start_ready_before_accept", 8'(bus.start_ready), 8'd1);
      bus.a           = av;
      bus.b           = bv;
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
   endtask

   task automatic job(input string tag, input logic [5:0] av, input logic [5:0] bv,
                      input logic g, input logic e, input int lat);
      accept(av, bv);
      wait_result(tag, lat);
      check({tag, "_gt"}, 8'(bus.gt), 8'(g));
      check({tag, "_eq"}, 8'(bus.eq), 8'(e));
      check({tag, "_ge"}, 8'(bus.ge), 8'(g | e));
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check({tag, "_idle_ready"}, 8'(bus.start_ready), 8'd1);
      check({tag, "_idle_valid"}, 8'(bus.res_valid), 8'd0);
      check({tag, "_held_ge"}, 8'(bus.ge), 8'(g | e));
   endtask

   initial begin
      n_assert        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      clr             = 1'b0;
      bus.start_valid = 1'b0;
      bus.res_ready   = 1'b0;
      bus.a           = '0;
      bus.b           = '0;

      #2;
      check("rst_start_ready", 8'(bus.start_ready), 8'd1);
      check("rst_res_valid", 8'(bus.res_valid), 8'd0);
      check("rst_gt", 8'(bus.gt), 8'd0);
      check("rst_eq", 8'(bus.eq), 8'd0);
      check("rst_ge", 8'(bus.ge), 8'd0);
      #10 rst_n = 1'b1;
      tick();

      // Normal comparisons: top, middle and bottom slice decisions plus equality.
      job("top_gt",  6'b110000, 6'b100000, 1'b1, 1'b0, 1);
      job("equal",   6'b101101, 6'b101101, 1'b0, 1'b1, 3);
      job("bot_gt",  6'b010011, 6'b010010, 1'b1, 1'b0, 3);
      job("bot_lt",  6'b000001, 6'b000010, 1'b0, 1'b0, 3);
      job("top_lt",  6'b100000, 6'b110000, 1'b0, 1'b0, 1);
      job("mid_gt",  6'b011100, 6'b011000, 1'b1, 1'b0, 2);
      job("zeros",   6'b000000, 6'b000000, 1'b0, 1'b1, 3);

      // Backpressure with a pending start request and toggling operands.
      accept(6'b001000, 6'b000100);
      wait_result("bp", 2);
      bus.start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.a = 6'(i * 13);
         bus.b = 6'(63 - i * 7);
         tick();
         check("bp_valid", 8'(bus.res_valid), 8'd1);
         check("bp_ready", 8'(bus.start_ready), 8'd0);
         check("bp_gt", 8'(bus.gt), 8'd1);
         check("bp_eq", 8'(bus.eq), 8'd0);
         check("bp_ge", 8'(bus.ge), 8'd1);
      end
      bus.a         = 6'b000000;
      bus.b         = 6'b000011;
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check("bp_release_ready", 8'(bus.start_ready), 8'd1);
      check("bp_release_valid", 8'(bus.res_valid), 8'd0);
      tick();
      bus.start_valid = 1'b0;
      check("bp_next_accepted", 8'(bus.start_ready), 8'd0);
      check("bp_next_cleared_gt", 8'(bus.gt), 8'd0);
      wait_result("bp_next", 3);
      check("bp_next_ge", 8'(bus.ge), 8'd0);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;

      // Abort one edge after acceptance.
      accept(6'b111111, 6'b111111);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("abort_ready", 8'(bus.start_ready), 8'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_valid", 8'(bus.res_valid), 8'd0);
      end
      check("abort_eq", 8'(bus.eq), 8'd0);
      check("abort_ge", 8'(bus.ge), 8'd0);

      // clr together with start_valid in IDLE must not accept.
      bus.a           = 6'b110000;
      bus.b           = 6'b000000;
      bus.start_valid = 1'b1;
      clr             = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      clr             = 1'b0;
      check("clr_start_ready", 8'(bus.start_ready), 8'd1);
      tick();
      check("clr_start_no_valid", 8'(bus.res_valid), 8'd0);
      check("clr_start_gt", 8'(bus.gt), 8'd0);

      // clr in DONE with res_ready high drops the result.
      accept(6'b101101, 6'b101101);
      wait_result("clr_done", 3);
      check("clr_done_eq_before", 8'(bus.eq), 8'd1);
      clr           = 1'b1;
      bus.res_ready = 1'b1;
      tick();
      clr           = 1'b0;
      bus.res_ready = 1'b0;
      check("clr_done_ready", 8'(bus.start_ready), 8'd1);
      check("clr_done_eq", 8'(bus.eq), 8'd0);
      check("clr_done_ge", 8'(bus.ge), 8'd0);

      // Asynchronous reset while holding a result in DONE.
      accept(6'b110000, 6'b100000);
      wait_result("arst", 1);
      check("arst_gt_before", 8'(bus.gt), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 8'(bus.res_valid), 8'd0);
      check("arst_ready", 8'(bus.start_ready), 8'd1);
      check("arst_gt", 8'(bus.gt), 8'd0);
      check("arst_eq", 8'(bus.eq), 8'd0);
      check("arst_ge", 8'(bus.ge), 8'd0);
      #2 rst_n = 1'b1;
      tick();
      check("arst_stays_idle", 8'(bus.res_valid), 8'd0);

      job("post_rst", 6'b001110, 6'b001101, 1'b1, 1'b0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
